// File: rtl/accel_cmd_pkg.sv
// -----------------------------------------------------------------------------
// accel_cmd_pkg
//
// Shared definitions for the matrix-accelerator command controller:
//   - funct codes of the custom instructions this block understands
//   - controller FSM state encoding
//   - sticky error codes reported on err_o
//
// Optional feature macro: ACCEL_CMD_CTRL_RESP_EN adds the RESP state.
// -----------------------------------------------------------------------------
package accel_cmd_pkg;

    localparam logic [6:0] FUNCT_INITIATE = 7'h01;
    localparam logic [6:0] FUNCT_SIZE     = 7'h02;
    localparam logic [6:0] FUNCT_ADDR_W   = 7'h04;
    localparam logic [6:0] FUNCT_ADDR_X   = 7'h06;
    localparam logic [6:0] FUNCT_ADDR_R   = 7'h08;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2
`ifdef ACCEL_CMD_CTRL_RESP_EN
        ,
        ST_RESP   = 2'd3
`endif
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE          = 2'd0,
        ERR_MISSING_CFG   = 2'd1,
        ERR_ILLEGAL_FUNCT = 2'd2,
        ERR_BAD_OPERAND   = 2'd3
    } err_e;

    // True for the four funct codes that write a configuration register.
    function automatic logic is_cfg_funct(input logic [6:0] funct);
        return (funct == FUNCT_SIZE)   || (funct == FUNCT_ADDR_W) ||
               (funct == FUNCT_ADDR_X) || (funct == FUNCT_ADDR_R);
    endfunction

endpackage

// File: rtl/accel_cfg_regs.sv
// -----------------------------------------------------------------------------
// accel_cfg_regs
//
// Holds the size and the three base addresses (W, X, R) with one valid bit
// each. A write is applied only when its operand is legal; an illegal operand
// leaves register and valid bit untouched and raises bad_operand_o for the
// controller to record. Contents persist across runs until reset.
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   wr_en_i        accepted command carrying this block's opcode
//   funct_i        command funct code (non-config codes are ignored here)
//   rs1_i          operand
//   size_o         latched size
//   addr_w_o/x/r   latched addresses
//   all_valid_o    all four registers have been written legally
//   bad_operand_o  current write is a config write with an illegal operand
// -----------------------------------------------------------------------------
module accel_cfg_regs
    import accel_cmd_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int ADDR_W    = 32,
    parameter int SIZE_W    = 16,
    parameter int MAX_SIZE  = 1024,
    parameter int ALIGN_LG2 = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [6:0]        funct_i,
    input  logic [XLEN-1:0]   rs1_i,
    output logic [SIZE_W-1:0] size_o,
    output logic [ADDR_W-1:0] addr_w_o,
    output logic [ADDR_W-1:0] addr_x_o,
    output logic [ADDR_W-1:0] addr_r_o,
    output logic              all_valid_o,
    output logic              bad_operand_o
);

    logic [SIZE_W-1:0] size_q, size_d;
    logic [ADDR_W-1:0] addr_w_q, addr_w_d;
    logic [ADDR_W-1:0] addr_x_q, addr_x_d;
    logic [ADDR_W-1:0] addr_r_q, addr_r_d;
    // valid bit order: [0] size, [1] W, [2] X, [3] R
    logic [3:0]        valid_q, valid_d;

    logic size_legal;
    logic addr_legal;

    assign size_legal = (rs1_i[XLEN-1:SIZE_W] == '0) &&
                        (rs1_i[SIZE_W-1:0] != '0) &&
                        (rs1_i[SIZE_W-1:0] <= SIZE_W'(MAX_SIZE));

    assign addr_legal = (rs1_i[XLEN-1:ADDR_W] == '0) &&
                        (rs1_i[ALIGN_LG2-1:0] == '0);

    always_comb begin
        // NOTE: every signal gets its hold value first, so no branch can leave
        // one unassigned and infer a latch.
        size_d        = size_q;
        addr_w_d      = addr_w_q;
        addr_x_d      = addr_x_q;
        addr_r_d      = addr_r_q;
        valid_d       = valid_q;
        bad_operand_o = 1'b0;

        if (wr_en_i) begin
            case (funct_i)
                FUNCT_SIZE: begin
                    if (size_legal) begin
                        size_d     = rs1_i[SIZE_W-1:0];
                        valid_d[0] = 1'b1;
                    end else begin
                        bad_operand_o = 1'b1;
                    end
                end
                FUNCT_ADDR_W: begin
                    if (addr_legal) begin
                        addr_w_d   = rs1_i[ADDR_W-1:0];
                        valid_d[1] = 1'b1;
                    end else begin
                        bad_operand_o = 1'b1;
                    end
                end
                FUNCT_ADDR_X: begin
                    if (addr_legal) begin
                        addr_x_d   = rs1_i[ADDR_W-1:0];
                        valid_d[2] = 1'b1;
                    end else begin
                        bad_operand_o = 1'b1;
                    end
                end
                FUNCT_ADDR_R: begin
                    if (addr_legal) begin
                        addr_r_d   = rs1_i[ADDR_W-1:0];
                        valid_d[3] = 1'b1;
                    end else begin
                        bad_operand_o = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: these registers are reset (not left as uninitialised storage)
    // because the valid bits gate INITIATE and the outputs must read zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            size_q   <= '0;
            addr_w_q <= '0;
            addr_x_q <= '0;
            addr_r_q <= '0;
            valid_q  <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            size_q   <= size_d;
            addr_w_q <= addr_w_d;
            addr_x_q <= addr_x_d;
            addr_r_q <= addr_r_d;
            valid_q  <= valid_d;
        end
    end

    assign size_o      = size_q;
    assign addr_w_o    = addr_w_q;
    assign addr_x_o    = addr_x_q;
    assign addr_r_o    = addr_r_q;
    assign all_valid_o = &valid_q;

endmodule

// File: rtl/accel_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// accel_cmd_ctrl
//
// RoCC-style command controller for the matrix accelerator. Commands arrive
// on a valid/ready handshake and are accepted only in IDLE. Commands with a
// foreign opcode are accepted and dropped. Config writes go to
// accel_cfg_regs; INITIATE launches the datapath (one-cycle start_o), after
// which a saturating counter measures BUSY cycles until done_i.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake
//   cmd_inst_funct_i           funct code
//   cmd_inst_opcode_i          opcode (only OPCODE is acted on)
//   cmd_inst_rd_i              destination register echoed in the response
//   cmd_rs1_i                  operand
//   cfg_size_o, cfg_addr_*_o   latched configuration
//   start_o                    one-cycle launch pulse
//   busy_o                     high from launch until the cycle after done_i
//   done_i                     datapath completion pulse (ignored unless BUSY)
//   err_o                      sticky error code (see accel_cmd_pkg::err_e)
//   resp_*                     response channel (macro build only)
//
// Optional feature macro: ACCEL_CMD_CTRL_RESP_EN. When defined, completion
// moves to RESP and presents {err_o, cycle count} with the captured rd until
// resp_ready_i. When undefined, BUSY returns straight to IDLE.
// -----------------------------------------------------------------------------
module accel_cmd_ctrl
    import accel_cmd_pkg::*;
#(
    parameter int         XLEN      = 64,
    parameter int         ADDR_W    = 32,
    parameter int         SIZE_W    = 16,
    parameter int         MAX_SIZE  = 1024,
    parameter int         ALIGN_LG2 = 3,
    parameter logic [6:0] OPCODE    = 7'h0B
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [6:0]        cmd_inst_funct_i,
    input  logic [6:0]        cmd_inst_opcode_i,
    input  logic [4:0]        cmd_inst_rd_i,
    input  logic [XLEN-1:0]   cmd_rs1_i,
    output logic [SIZE_W-1:0] cfg_size_o,
    output logic [ADDR_W-1:0] cfg_addr_w_o,
    output logic [ADDR_W-1:0] cfg_addr_x_o,
    output logic [ADDR_W-1:0] cfg_addr_r_o,
    output logic              start_o,
    output logic              busy_o,
    input  logic              done_i,
    output logic [1:0]        err_o
`ifdef ACCEL_CMD_CTRL_RESP_EN
    ,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [4:0]        resp_rd_o,
    output logic [XLEN-1:0]   resp_data_o
`endif
);

    localparam int CNT_W = XLEN - 2;

    state_e           state_q, state_d;
    err_e             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic own_cmd;
    logic is_initiate;
    logic cfg_all_valid;
    logic cfg_bad_operand;

    assign cmd_ready_o = (state_q == ST_IDLE);
    // Foreign opcodes still complete the handshake; they just never act.
    assign own_cmd     = cmd_valid_i && cmd_ready_o &&
                         (cmd_inst_opcode_i == OPCODE);
    assign is_initiate = (cmd_inst_funct_i == FUNCT_INITIATE);

    accel_cfg_regs #(
        .XLEN      (XLEN),
        .ADDR_W    (ADDR_W),
        .SIZE_W    (SIZE_W),
        .MAX_SIZE  (MAX_SIZE),
        .ALIGN_LG2 (ALIGN_LG2)
    ) u_cfg_regs (
        .clk           (clk),
        .reset         (reset),
        .wr_en_i       (own_cmd),
        .funct_i       (cmd_inst_funct_i),
        .rs1_i         (cmd_rs1_i),
        .size_o        (cfg_size_o),
        .addr_w_o      (cfg_addr_w_o),
        .addr_x_o      (cfg_addr_x_o),
        .addr_r_o      (cfg_addr_r_o),
        .all_valid_o   (cfg_all_valid),
        .bad_operand_o (cfg_bad_operand)
    );

`ifdef ACCEL_CMD_CTRL_RESP_EN
    logic [4:0] rd_q, rd_d;
`else
    logic unused_rd;
    assign unused_rd = ^cmd_inst_rd_i;
`endif

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef ACCEL_CMD_CTRL_RESP_EN
        rd_d    = rd_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (own_cmd) begin
                    if (is_initiate) begin
                        if (cfg_all_valid) begin
                            err_d   = ERR_NONE;
                            cnt_d   = '0;
                            state_d = ST_LAUNCH;
`ifdef ACCEL_CMD_CTRL_RESP_EN
                            rd_d    = cmd_inst_rd_i;
`endif
                        end else begin
                            err_d = ERR_MISSING_CFG;
                        end
                    end else if (is_cfg_funct(cmd_inst_funct_i)) begin
                        if (cfg_bad_operand) begin
                            err_d = ERR_BAD_OPERAND;
                        end
                    end else begin
                        err_d = ERR_ILLEGAL_FUNCT;
                    end
                end
            end
            ST_LAUNCH: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (done_i) begin
`ifdef ACCEL_CMD_CTRL_RESP_EN
                    state_d = ST_RESP;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef ACCEL_CMD_CTRL_RESP_EN
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            err_q   <= ERR_NONE;
            cnt_q   <= '0;
`ifdef ACCEL_CMD_CTRL_RESP_EN
            rd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef ACCEL_CMD_CTRL_RESP_EN
            rd_q    <= rd_d;
`endif
        end
    end

    assign start_o = (state_q == ST_LAUNCH);
    assign busy_o  = (state_q == ST_LAUNCH) || (state_q == ST_BUSY);
    assign err_o   = err_q;

`ifdef ACCEL_CMD_CTRL_RESP_EN
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_rd_o    = rd_q;
    assign resp_data_o  = {err_q, cnt_q};
`endif

endmodule

// File: tb/tb_accel_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_accel_cmd_ctrl
//
// Self-checking bench for accel_cmd_ctrl. A behavioural model tracks the
// configuration registers, valid bits, sticky error and captured rd, and
// each scenario task compares DUT outputs against it. Works with or without
// ACCEL_CMD_CTRL_RESP_EN.
// -----------------------------------------------------------------------------
module tb_accel_cmd_ctrl;
    import accel_cmd_pkg::*;

    localparam int XLEN = 64;
    localparam logic [6:0] OPC = 7'h0B;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic [6:0]        cmd_inst_funct_i = '0;
    logic [6:0]        cmd_inst_opcode_i = '0;
    logic [4:0]        cmd_inst_rd_i = '0;
    logic [XLEN-1:0]   cmd_rs1_i = '0;
    logic [15:0]       cfg_size_o;
    logic [31:0]       cfg_addr_w_o, cfg_addr_x_o, cfg_addr_r_o;
    logic              start_o, busy_o;
    logic              done_i = 1'b0;
    logic [1:0]        err_o;
`ifdef ACCEL_CMD_CTRL_RESP_EN
    logic              resp_valid_o;
    logic              resp_ready_i = 1'b0;
    logic [4:0]        resp_rd_o;
    logic [XLEN-1:0]   resp_data_o;
`endif

    always #5 clk = ~clk;

    accel_cmd_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .cmd_valid_i       (cmd_valid_i),
        .cmd_ready_o       (cmd_ready_o),
        .cmd_inst_funct_i  (cmd_inst_funct_i),
        .cmd_inst_opcode_i (cmd_inst_opcode_i),
        .cmd_inst_rd_i     (cmd_inst_rd_i),
        .cmd_rs1_i         (cmd_rs1_i),
        .cfg_size_o        (cfg_size_o),
        .cfg_addr_w_o      (cfg_addr_w_o),
        .cfg_addr_x_o      (cfg_addr_x_o),
        .cfg_addr_r_o      (cfg_addr_r_o),
        .start_o           (start_o),
        .busy_o            (busy_o),
        .done_i            (done_i),
        .err_o             (err_o)
`ifdef ACCEL_CMD_CTRL_RESP_EN
        ,
        .resp_valid_o      (resp_valid_o),
        .resp_ready_i      (resp_ready_i),
        .resp_rd_o         (resp_rd_o),
        .resp_data_o       (resp_data_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [15:0] m_size;
    logic [31:0] m_addr [3];   // W, X, R
    bit          m_valid [4];  // size, W, X, R
    logic [1:0]  m_err;
    logic [4:0]  m_rd;
    bit          launched;

    function automatic logic [113:0] exp_snap();
        return {m_err, m_size, m_addr[0], m_addr[1], m_addr[2]};
    endfunction

    function automatic logic [113:0] act_snap();
        return {err_o, cfg_size_o, cfg_addr_w_o, cfg_addr_x_o, cfg_addr_r_o};
    endfunction

    task automatic model_reset();
        m_size = '0;
        for (int i = 0; i < 3; i++) m_addr[i] = '0;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        m_err = 2'd0;
        m_rd  = '0;
    endtask

    task automatic model_cmd(input logic [6:0] f, input logic [6:0] op,
                             input logic [63:0] v, input logic [4:0] rd,
                             output bit launch);
        int idx;
        launch = 1'b0;
        if (op != OPC) return;
        case (f)
            7'h01: begin
                if (m_valid[0] && m_valid[1] && m_valid[2] && m_valid[3]) begin
                    m_err  = 2'd0;
                    m_rd   = rd;
                    launch = 1'b1;
                end else begin
                    m_err = 2'd1;
                end
            end
            7'h02: begin
                if (v >= 64'd1 && v <= 64'd1024) begin
                    m_size     = v[15:0];
                    m_valid[0] = 1'b1;
                end else begin
                    m_err = 2'd3;
                end
            end
            7'h04, 7'h06, 7'h08: begin
                idx = (int'(f) - 4) / 2;
                if (v < 64'h1_0000_0000 && (v % 64'd8) == 64'd0) begin
                    m_addr[idx]    = v[31:0];
                    m_valid[idx+1] = 1'b1;
                end else begin
                    m_err = 2'd3;
                end
            end
            default: m_err = 2'd2;
        endcase
    endtask

    // ---------------- stimulus primitives ----------------
    task automatic do_reset();
        cmd_valid_i = 1'b0;
        done_i      = 1'b0;
`ifdef ACCEL_CMD_CTRL_RESP_EN
        resp_ready_i = 1'b0;
`endif
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // Issue one command from IDLE and compare the cycle after acceptance.
    task automatic issue(input logic [6:0] f, input logic [6:0] op,
                         input logic [63:0] v, input logic [4:0] rd,
                         input string tag);
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before got=%b want=1", tag, cmd_ready_o);
        end
        cmd_valid_i       = 1'b1;
        cmd_inst_funct_i  = f;
        cmd_inst_opcode_i = op;
        cmd_rs1_i         = v;
        cmd_inst_rd_i     = rd;
        @(posedge clk);
        #1 cmd_valid_i = 1'b0;
        model_cmd(f, op, v, rd, launched);
        checks++;
        if ({start_o, busy_o, cmd_ready_o} !== {launched, launched, !launched}) begin
            errors++;
            $display("FAIL %s start_busy_ready got=%b%b%b want=%b%b%b", tag,
                     start_o, busy_o, cmd_ready_o, launched, launched, !launched);
        end
        checks++;
        if (act_snap() !== exp_snap()) begin
            errors++;
            $display("FAIL %s cfg_err got=%h want=%h", tag, act_snap(), exp_snap());
        end
    endtask

    // Called in LAUNCH right after issue(); done_i in the n-th BUSY cycle.
    task automatic finish_job(input int n, input int hold, input string tag);
        @(posedge clk);
        #1;
        for (int i = 1; i <= n; i++) begin
            checks++;
            if ({start_o, busy_o, cmd_ready_o} !== 3'b010) begin
                errors++;
                $display("FAIL %s busy_cycle%0d start_busy_ready got=%b%b%b want=010",
                         tag, i, start_o, busy_o, cmd_ready_o);
            end
            if (i == n) done_i = 1'b1;
            @(posedge clk);
            #1 done_i = 1'b0;
        end
        checks++;
        if ({start_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL %s after_done start_busy got=%b%b want=00", tag, start_o, busy_o);
        end
`ifdef ACCEL_CMD_CTRL_RESP_EN
        for (int h = 0; h <= hold; h++) begin
            if (h == hold) resp_ready_i = 1'b1;
            checks++;
            if ({resp_valid_o, cmd_ready_o} !== 2'b10 ||
                resp_data_o !== {m_err, 62'(n)} || resp_rd_o !== m_rd) begin
                errors++;
                $display("FAIL %s resp h%0d valid=%b ready=%b data=%h rd=%0d want 1 0 %h %0d",
                         tag, h, resp_valid_o, cmd_ready_o, resp_data_o, resp_rd_o,
                         {m_err, 62'(n)}, m_rd);
            end
            @(posedge clk);
            #1;
        end
        resp_ready_i = 1'b0;
        checks++;
        if (resp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s resp_drop got=%b want=0", tag, resp_valid_o);
        end
`else
        if (hold < 0) $display("hold %0d", hold);
`endif
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_after got=%b want=1", tag, cmd_ready_o);
        end
    endtask

    task automatic configure_default(input string tag);
        issue(FUNCT_SIZE,   OPC, 64'd16,     5'd0, {tag, "_size"});
        issue(FUNCT_ADDR_W, OPC, 64'h1000,   5'd0, {tag, "_addr_w"});
        issue(FUNCT_ADDR_X, OPC, 64'h2000,   5'd0, {tag, "_addr_x"});
        issue(FUNCT_ADDR_R, OPC, 64'h3000,   5'd0, {tag, "_addr_r"});
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({cmd_ready_o, start_o, busy_o} !== 3'b100) begin
            errors++;
            $display("FAIL reset ready_start_busy got=%b%b%b want=100",
                     cmd_ready_o, start_o, busy_o);
        end
        checks++;
        if (act_snap() !== exp_snap()) begin
            errors++;
            $display("FAIL reset cfg_err got=%h want=%h", act_snap(), exp_snap());
        end
`ifdef ACCEL_CMD_CTRL_RESP_EN
        checks++;
        if (resp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset resp_valid got=%b want=0", resp_valid_o);
        end
`endif
    endtask

    task automatic test_basic_launch();
        do_reset();
        configure_default("basic");
        issue(FUNCT_INITIATE, OPC, 64'd0, 5'd5, "basic_init");
        finish_job(10, 3, "basic_job");
        // Registers persist: second launch with done_i in the first BUSY cycle.
        issue(FUNCT_INITIATE, OPC, 64'd0, 5'd9, "minlat_init");
        finish_job(1, 0, "minlat_job");
    endtask

    task automatic test_missing_config();
        do_reset();
        issue(FUNCT_SIZE, OPC, 64'd16, 5'd0, "missing_size");
        issue(FUNCT_INITIATE, OPC, 64'd0, 5'd1, "missing_init");
        @(posedge clk);
        #1;
        checks++;
        if ({start_o, busy_o, cmd_ready_o} !== 3'b001) begin
            errors++;
            $display("FAIL missing_next start_busy_ready got=%b%b%b want=001",
                     start_o, busy_o, cmd_ready_o);
        end
    endtask

    task automatic test_bad_operands();
        do_reset();
        configure_default("bad_cfg");
        issue(FUNCT_SIZE,   OPC, 64'd0,          5'd0, "bad_size0");
        issue(FUNCT_SIZE,   OPC, 64'd1025,       5'd0, "bad_size_max1");
        issue(FUNCT_SIZE,   OPC, 64'h1_0000_0010, 5'd0, "bad_size_hi");
        issue(FUNCT_SIZE,   OPC, 64'd1024,       5'd0, "size_max");
        issue(FUNCT_ADDR_X, OPC, 64'h1004,       5'd0, "bad_align");
        issue(FUNCT_ADDR_W, OPC, 64'h1_0000_0000, 5'd0, "bad_addr_hi");
        issue(FUNCT_ADDR_R, OPC, 64'hFFFF_FFF8,  5'd0, "addr_top");
        issue(7'h07,        OPC, 64'd0,          5'd0, "bad_funct");
        issue(7'h02,        7'h33, 64'd0,        5'd0, "foreign_opcode");
        issue(FUNCT_INITIATE, OPC, 64'd0,        5'd3, "bad_then_init");
        finish_job(4, 1, "bad_job");
    endtask

    task automatic test_busy_hold();
        issue(FUNCT_INITIATE, OPC, 64'd0, 5'd7, "hold_init");
        cmd_valid_i       = 1'b1;
        cmd_inst_funct_i  = FUNCT_SIZE;
        cmd_inst_opcode_i = OPC;
        cmd_rs1_i         = 64'd32;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (cmd_ready_o !== 1'b0 || act_snap() !== exp_snap()) begin
                errors++;
                $display("FAIL hold_busy%0d ready=%b cfg=%h want ready=0 cfg=%h",
                         i, cmd_ready_o, act_snap(), exp_snap());
            end
        end
        cmd_valid_i = 1'b0;
        done_i      = 1'b1;
        @(posedge clk);
        #1 done_i = 1'b0;
`ifdef ACCEL_CMD_CTRL_RESP_EN
        resp_ready_i = 1'b1;
        @(posedge clk);
        #1 resp_ready_i = 1'b0;
`endif
        checks++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || act_snap() !== exp_snap()) begin
            errors++;
            $display("FAIL hold_end ready=%b busy=%b cfg=%h want 1 0 %h",
                     cmd_ready_o, busy_o, act_snap(), exp_snap());
        end
        // Stray done_i while idle must do nothing.
        done_i = 1'b1;
        @(posedge clk);
        #1 done_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({start_o, busy_o, cmd_ready_o} !== 3'b001 || act_snap() !== exp_snap()) begin
            errors++;
            $display("FAIL stray_done sbr=%b%b%b cfg=%h want 001 %h",
                     start_o, busy_o, cmd_ready_o, act_snap(), exp_snap());
        end
    endtask

    task automatic test_reset_mid_busy();
        issue(FUNCT_INITIATE, OPC, 64'd0, 5'd2, "rst_init");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({start_o, busy_o} !== 2'b00 || act_snap() !== exp_snap()) begin
            errors++;
            $display("FAIL rst_mid start=%b busy=%b cfg=%h want 0 0 %h",
                     start_o, busy_o, act_snap(), exp_snap());
        end
`ifdef ACCEL_CMD_CTRL_RESP_EN
        checks++;
        if (resp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid resp_valid got=%b want=0", resp_valid_o);
        end
`endif
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        // Valid bits were cleared, so this INITIATE must report missing config.
        issue(FUNCT_INITIATE, OPC, 64'd0, 5'd2, "rst_reinit");
    endtask

    task automatic test_random();
        logic [6:0]  ftab [10] = '{7'h01, 7'h02, 7'h04, 7'h06, 7'h08,
                                   7'h02, 7'h04, 7'h06, 7'h08, 7'h00};
        logic [6:0]  f, op;
        logic [63:0] v;
        int          sel;
        do_reset();
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                done_i = 1'b1;
                @(posedge clk);
                #1 done_i = 1'b0;
            end
            sel = $urandom_range(0, 9);
            f   = (sel == 9) ? 7'($urandom()) : ftab[sel];
            op  = ($urandom_range(0, 9) == 0) ? 7'($urandom()) : OPC;
            case ($urandom_range(0, 5))
                0:       v = 64'($urandom_range(1, 1024));
                1:       v = {32'h0, $urandom() & 32'hFFFF_FFF8};
                2:       v = {32'h0, $urandom()};
                3:       v = {$urandom(), $urandom()};
                4:       v = 64'd0;
                default: v = 64'($urandom_range(1020, 1030));
            endcase
            issue(f, op, v, 5'($urandom()), "rand");
            if (launched) finish_job($urandom_range(1, 12), $urandom_range(0, 3), "rand_job");
        end
    endtask

    initial begin
        test_reset();
        test_basic_launch();
        test_missing_config();
        test_bad_operands();
        test_busy_hold();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/accel_cmd_ctrl.md
# accel_cmd_ctrl

Parametrised RoCC-style command controller for the matrix accelerator, the successor to the fixed-width command decoder. It accepts custom instructions over a valid/ready handshake, validates and latches the size and three base addresses (W, X, R), launches the datapath on INITIATE, and tracks completion with a busy-cycle counter. An optional response channel returns status and cycle count to the core.

## Interface
- XLEN, 64, width of cmd_rs1_i and resp_data_o
- ADDR_W, 32, width of each latched address
- SIZE_W, 16, width of latched size
- MAX_SIZE, 1024, largest legal size
- ALIGN_LG2, 3, required address alignment (low bits zero)
- OPCODE, 7'h0B, custom opcode this block owns

- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready
- cmd_inst_funct_i  in  7  command function code
- cmd_inst_opcode_i  in  7  instruction opcode
- cmd_inst_rd_i  in  5  destination register, captured for response
- cmd_rs1_i  in  XLEN  operand
- cfg_size_o  out  SIZE_W  latched size
- cfg_addr_w_o / cfg_addr_x_o / cfg_addr_r_o  out  ADDR_W  latched addresses
- start_o  out  1  one-cycle launch pulse
- busy_o  out  1  high from launch until done
- done_i  in  1  datapath completion pulse
- err_o  out  2  sticky error code: 0 none, 1 missing config, 2 illegal funct, 3 bad operand
- resp_valid_o, resp_ready_i, resp_rd_o[4:0], resp_data_o[XLEN-1:0]  response channel (macro only)

## Operation
- Funct codes: INITIATE 0x1, SIZE 0x2, ADDR_W 0x4, ADDR_X 0x6, ADDR_R 0x8.
- FSM states IDLE, LAUNCH, BUSY, RESP. cmd_ready_o = 1 only in IDLE.
- Accept = cmd_valid_i & cmd_ready_o. Opcode != OPCODE: accepted, dropped, no effect.
- SIZE: legal iff rs1[XLEN-1:SIZE_W] == 0 and 1 <= value <= MAX_SIZE; else err 3, register and valid bit unchanged.
- ADDR_*: legal iff rs1[XLEN-1:ADDR_W] == 0 and rs1[ALIGN_LG2-1:0] == 0; else err 3.
- Legal write updates register and sets its valid bit; registers and valid bits persist across runs.
- Unknown funct: err 2, no state change.
- INITIATE with all four valid bits: clear err_o, clear cycle counter, IDLE -> LAUNCH; otherwise err 1, stay IDLE.
- LAUNCH: start_o = 1 for exactly one cycle, -> BUSY.
- BUSY: counter increments each cycle, saturating at all-ones (XLEN-2 bits). done_i -> RESP (macro) or IDLE.
- done_i outside BUSY is ignored. Error codes are sticky; a later error overwrites an earlier one.

## Timing
- Reset: state IDLE, all cfg registers, valid bits, counter, err_o, start_o, busy_o, resp_valid_o = 0; cmd_ready_o = 1 after reset release.
- Config outputs update the cycle after accept.
- start_o asserted the cycle after INITIATE accept; busy_o rises with start_o, falls the cycle after done_i.
- Minimum INITIATE-to-ready latency, done_i in first BUSY cycle, no macro: 3 cycles.
- Response: resp_valid_o the cycle after done_i; holds with stable data until resp_ready_i; then IDLE next cycle.
- Reset asserted mid-run aborts immediately to reset values; no response issued.

## Configuration
- ACCEL_CMD_CTRL_RESP_EN defined: response ports and RESP state present; resp_rd_o = rd captured at INITIATE, resp_data_o = {err_o, cycle count}, zero-extended to XLEN.
- Undefined: response ports and RESP state absent, BUSY returns directly to IDLE, cmd_inst_rd_i ignored.

## Structure
- Package accel_cmd_pkg: funct localparams, state enum, error-code enum.
- Sub-module accel_cfg_regs: the four config registers plus valid bits with legality checks; FSM and counter stay in top.

## Test plan
- Reset, write SIZE=16, ADDR_W=0x1000, ADDR_X=0x2000, ADDR_R=0x3000, INITIATE -> start_o pulse one cycle later, busy_o high, outputs match.
- INITIATE after reset with only SIZE written -> err_o=1, no start_o, ready stays 1.
- SIZE=0, SIZE=MAX_SIZE+1, ADDR_X=0x1004 (ALIGN_LG2=3) -> err_o=3, registers unchanged; funct 0x7 -> err_o=2.
- done_i after 10 BUSY cycles, macro on, resp_ready_i held low 3 cycles -> resp_valid_o stable, resp_data_o=10, resp_rd_o=captured rd.
- cmd_valid_i held during BUSY -> cmd_ready_o=0, no register change; stray done_i in IDLE -> no effect.
- reset asserted mid-BUSY -> all outputs zero immediately, IDLE, valid bits cleared.
